// File: rtl/multicycle_controller.sv
// Multicycle control sequencer for the ARM-subset datapath: instruction decode,
// NZCV flag register, condition evaluation and the fetch/decode/execute/memory/writeback walk.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [3:0]  ALUControl,
    output logic        MemtoReg,
    output logic [3:0]  Flags,
    output logic [2:0]  state,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cond;
    op_e        op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       sl_bit;
    logic [3:0] rd;
    logic       unused_instr_bits;

    assign cond   = Instr[31:28];
    assign op     = op_e'(Instr[27:26]);
    assign i_bit  = Instr[25];
    assign cmd    = Instr[24:21];
    assign sl_bit = Instr[20];
    assign rd     = Instr[15:12];
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    logic [3:0] dp_alu_ctl;
    logic       dp_writes;
    logic       dp_supported;
    logic       dp_is_cmp;
    logic       dp_flag_upd;

    always_comb begin
        dp_alu_ctl   = '0;
        dp_writes    = 1'b0;
        dp_supported = 1'b1;
        dp_is_cmp    = 1'b0;
        case (cmd)
            4'b0100: begin dp_alu_ctl = 4'b0000; dp_writes = 1'b1; end
            4'b0010: begin dp_alu_ctl = 4'b0001; dp_writes = 1'b1; end
            4'b0000: begin dp_alu_ctl = 4'b0010; dp_writes = 1'b1; end
            4'b1100: begin dp_alu_ctl = 4'b0011; dp_writes = 1'b1; end
            4'b1010: begin dp_alu_ctl = 4'b0001; dp_is_cmp = 1'b1; end
            default: dp_supported = 1'b0;
        endcase
    end

    // CMP always updates flags even with S clear
    assign dp_flag_upd = dp_is_cmp | (sl_bit & dp_supported);

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;
    logic skip;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign skip = ~cond_pass | (op == OP_ILL);

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = imem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = skip ? S_FETCH : S_EXECUTE;
            S_EXECUTE: begin
                state_d = (op == OP_MEM) ? S_MEMORY : S_FETCH;
                if (op == OP_DP && dp_flag_upd) begin
                    flags_d = ALUFlags;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    state_d = sl_bit ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    logic in_instr;

    assign in_instr = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                      (state_q == S_MEMORY) || (state_q == S_WRITEBACK);

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        RegSrc     = '0;
        RegWrite   = 1'b0;
        ImmSrc     = '0;
        ALUSrc     = 1'b0;
        ALUControl = '0;
        MemtoReg   = 1'b0;
        instr_done = 1'b0;

        if (in_instr) begin
            case (op)
                OP_DP: begin
                    ImmSrc     = 2'b00;
                    ALUSrc     = i_bit;
                    RegSrc     = 2'b00;
                    ALUControl = dp_alu_ctl;
                end
                OP_MEM: begin
                    ImmSrc = 2'b01;
                    ALUSrc = 1'b1;
                    RegSrc = {~sl_bit, 1'b0};
                end
                OP_BR: begin
                    ImmSrc = 2'b10;
                    ALUSrc = 1'b1;
                    RegSrc = 2'b01;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                IRWrite  = imem_ready;
            end
            S_DECODE: begin
                if (skip) begin
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_EXECUTE: begin
                case (op)
                    OP_DP: begin
                        RegWrite   = dp_writes;
                        PCWrite    = 1'b1;
                        PCSrc      = dp_writes & (rd == 4'hF);
                        instr_done = 1'b1;
                    end
                    OP_BR: begin
                        PCWrite    = 1'b1;
                        PCSrc      = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_MEM: ;
                    default: begin
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                MemWrite = ~sl_bit;
                if (dmem_ready && !sl_bit) begin
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WRITEBACK: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                PCWrite    = 1'b1;
                PCSrc      = (rd == 4'hF);
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign Flags = flags_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        imem_ready, dmem_ready;
    logic        imem_req, dmem_req, MemWrite, IRWrite, PCWrite, PCSrc;
    logic [1:0]  RegSrc, ImmSrc;
    logic        RegWrite, ALUSrc, MemtoReg, instr_done;
    logic [3:0]  ALUControl, Flags;
    logic [2:0]  state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegSrc(RegSrc),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .MemtoReg(MemtoReg), .Flags(Flags),
        .state(state), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    logic [24:0] all_out;
    assign all_out = {imem_req, dmem_req, MemWrite, IRWrite, PCWrite, PCSrc, RegSrc,
                      RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, Flags, state, instr_done};

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [3:0]  mflags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (Instr=%h t=%0t)", tag, obs, exp, Instr, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] fl);
        bit n, z, cy, v;
        {n, z, cy, v} = fl;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One instruction from its FETCH cycle to retire; f/m are fetch/data ready-low cycles.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                             input int unsigned f, input int unsigned m);
        logic [1:0] op;
        logic [3:0] cmd;
        bit skip, is_mem, ldr, wr, upd, done, pcsrc_at, mtr_at, exp_pcsrc, sup;
        int unsigned exp_cyc, exp_state, cyc, fcnt, mcnt;
        int unsigned n_pcw, pcw_at, n_rw, rw_at, n_irw, irw_at, n_ireq, n_dreq, mw_bad;
        logic [1:0] e_imm, e_rsrc, o_imm, o_rsrc;
        logic       e_asrc, o_asrc;
        logic [3:0] e_alu, o_alu;
        logic [2:0] st_at;

        @(posedge clk); #1;
        Instr = ins;
        ALUFlags = af;
        check("flags_before", Flags, mflags);
        check("fetch_state", state, 3'd1);

        op  = ins[27:26];
        cmd = ins[24:21];
        ldr = ins[20];
        skip   = (op == 2'b11) || !cond_holds(ins[31:28], mflags);
        is_mem = !skip && op == 2'b01;
        sup = (cmd == 4'h4 || cmd == 4'h2 || cmd == 4'h0 || cmd == 4'hC || cmd == 4'hA);
        wr  = !skip && op == 2'b00 && sup && cmd != 4'hA;
        upd = !skip && op == 2'b00 && (cmd == 4'hA || (ins[20] && sup));
        e_alu = 4'h0;
        if (op == 2'b00) begin
            case (cmd)
                4'h2, 4'hA: e_alu = 4'h1;
                4'h0:       e_alu = 4'h2;
                4'hC:       e_alu = 4'h3;
                default:    e_alu = 4'h0;
            endcase
        end
        e_imm  = (op == 2'b00) ? 2'b00 : (op == 2'b01) ? 2'b01 : 2'b10;
        e_asrc = (op == 2'b00) ? ins[25] : 1'b1;
        e_rsrc = (op == 2'b00) ? 2'b00 : (op == 2'b01) ? {~ldr, 1'b0} : 2'b01;

        if (skip) begin
            exp_cyc = 2; exp_state = 2; exp_pcsrc = 1'b0;
        end else if (op == 2'b01) begin
            exp_cyc   = (ldr ? 5 : 4) + m;
            exp_state = ldr ? 5 : 4;
            exp_pcsrc = ldr && ins[15:12] == 4'hF;
            wr        = ldr;
        end else begin
            exp_cyc   = 3; exp_state = 3;
            exp_pcsrc = (op == 2'b10) ? 1'b1 : (wr && ins[15:12] == 4'hF);
        end
        exp_cyc += f;

        cyc = 0; fcnt = 0; mcnt = 0; done = 0;
        n_pcw = 0; pcw_at = 0; n_rw = 0; rw_at = 0; n_irw = 0; irw_at = 0;
        n_ireq = 0; n_dreq = 0; mw_bad = 0; pcsrc_at = 0; mtr_at = 0;
        o_imm = '0; o_rsrc = '0; o_asrc = 0; o_alu = '0; st_at = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            imem_ready = imem_req ? (fcnt >= f) : 1'($urandom_range(0, 1));
            dmem_ready = dmem_req ? (mcnt >= m) : 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (imem_req) fcnt++;
            if (IRWrite) begin n_irw++; irw_at = cyc; end
            if (imem_req) n_ireq++;
            if (dmem_req) begin
                n_dreq++;
                mcnt++;
                if (MemWrite !== ~ldr) mw_bad++;
            end else if (MemWrite) mw_bad++;
            if (PCWrite) begin n_pcw++; pcw_at = cyc; pcsrc_at = PCSrc; end
            if (RegWrite) begin n_rw++; rw_at = cyc; mtr_at = MemtoReg; end
            if (instr_done) begin
                done = 1;
                st_at = state;
                o_imm = ImmSrc; o_rsrc = RegSrc; o_asrc = ALUSrc; o_alu = ALUControl;
            end
        end

        check("retired", done, 1'b1);
        check("cycles", cyc, exp_cyc);
        check("retire_state", st_at, exp_state);
        check("pcwrite_count", n_pcw, 1);
        check("pcwrite_cycle", pcw_at, exp_cyc);
        check("pcsrc", pcsrc_at, exp_pcsrc);
        check("regwrite_count", n_rw, wr ? 1 : 0);
        if (wr) begin
            check("regwrite_cycle", rw_at, exp_cyc);
            check("memtoreg", mtr_at, is_mem);
        end
        check("irwrite_count", n_irw, 1);
        check("irwrite_cycle", irw_at, f + 1);
        check("imem_req_cycles", n_ireq, f + 1);
        check("dmem_req_cycles", n_dreq, is_mem ? m + 1 : 0);
        check("memwrite", mw_bad, 0);
        if (op != 2'b11) begin
            check("immsrc", o_imm, e_imm);
            check("alusrc", o_asrc, e_asrc);
            check("regsrc", o_rsrc, e_rsrc);
            check("alucontrol", o_alu, e_alu);
        end
        if (upd) mflags = af;
    endtask

    task automatic reset_mid_memory();
        int unsigned cyc;
        @(posedge clk); #1;
        Instr = 32'hE5912004;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        cyc = 0;
        while (dmem_req !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            imem_ready = 1'b1;
            dmem_ready = 1'b0;
            #1;
            cyc++;
        end
        check("reach_memory", dmem_req, 1'b1);
        reset = 1'b0;
        #1;
        check("reset_mid_outputs", all_out, '0);
        mflags = 4'h0;
        @(negedge clk); #1;
        check("reset_held_outputs", all_out, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        check("idle_after_reset", all_out, '0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [3:0]  cmds [6];
        int unsigned k;
        w = $urandom;
        cmds[0] = 4'h4; cmds[1] = 4'h2; cmds[2] = 4'h0;
        cmds[3] = 4'hC; cmds[4] = 4'hA; cmds[5] = 4'($urandom);
        if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
        k = $urandom_range(0, 9);
        w[27:26] = (k < 4) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
        if (w[27:26] == 2'b00) w[24:21] = cmds[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
        return w;
    endfunction

    initial begin
        reset = 1'b0;
        Instr = '0;
        ALUFlags = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        mflags = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check("in_reset_outputs", all_out, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        check("idle_outputs", all_out, '0);

        run_instr(32'hE2821005, 4'b1111, 0, 0);
        run_instr(32'hE3500000, 4'b0100, 0, 0);
        run_instr(32'h0A000002, 4'b0000, 0, 0);
        run_instr(32'h1A000002, 4'b1011, 0, 0);
        run_instr(32'hE5912004, 4'b0000, 0, 3);
        run_instr(32'hE5812000, 4'b0000, 2, 0);
        run_instr(32'hE3500000, 4'b1010, 0, 0);
        reset_mid_memory();

        for (int i = 0; i < 250; i++) begin
            run_instr(rand_instr(), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(posedge clk); #1;
        check("final_flags", Flags, mflags);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
